// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw level in, and the debounced level with its
// qualification and long-press flags out.
interface button_debouncer_if;
  logic btn_raw;
  logic btn_signal;
  logic busy;
  logic held;

  modport master (
    output btn_raw,
    input  btn_signal,
    input  busy,
    input  held
  );

  modport slave (
    input  btn_raw,
    output btn_signal,
    output busy,
    output held
  );
endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, stable-window debounce and
// a saturating long-press timer, all in the clk_4 domain.
module button_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 8,
  parameter int CNT_W         = 8
) (
  input  logic         clk_4,
  input  logic         reset,
  button_debouncer_if.slave bus
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             btn_q, btn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;

  always_ff @(posedge clk_4 or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      btn_q  <= 1'b0;
      cnt_q  <= '0;
      hcnt_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      btn_q  <= btn_d;
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  always_comb begin
    s1_d  = bus.btn_raw;
    s2_d  = s1_q;
    btn_d = btn_q;
    cnt_d = cnt_q;
    // Any return of s2 to the current level throws the partial count away.
    if (s2_q == btn_q) begin
      cnt_d = '0;
    end else if (cnt_q == STABLE_LAST) begin
      btn_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counting starts the edge after the rise, so held lands HOLD_CYCLES later.
  always_comb begin
    hcnt_d = hcnt_q;
    if (!btn_d) begin
      hcnt_d = '0;
    end else if (btn_q && (hcnt_q != HOLD_MAX)) begin
      hcnt_d = hcnt_q + CNT_ONE;
    end
  end

  assign bus.btn_signal = btn_q;
  assign bus.busy       = (cnt_q != '0);
  assign bus.held       = (hcnt_q == HOLD_MAX);

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised bench for button_debouncer: default and minimum-parameter
// instances share one raw button and are checked against a window model.
module tb_button_debouncer;

  localparam int N     = 8000;
  localparam int START = 10;
  localparam int S_A = 4, H_A = 8;
  localparam int S_B = 1, H_B = 1;

  logic clk_4 = 1'b0;
  logic reset;
  logic raw;

  always #5 clk_4 = ~clk_4;

  button_debouncer_if bus_a();
  button_debouncer_if bus_b();
  assign bus_a.btn_raw = raw;
  assign bus_b.btn_raw = raw;

  button_debouncer #(.STABLE_CYCLES(S_A), .HOLD_CYCLES(H_A), .CNT_W(8)) u_dut_a (
    .clk_4 (clk_4),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  button_debouncer #(.STABLE_CYCLES(S_B), .HOLD_CYCLES(H_B), .CNT_W(8)) u_dut_b (
    .clk_4 (clk_4),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  // Per-edge history: raw level and reset seen at each rising edge, and the
  // modelled debounced level after each edge for both instances.
  bit raw_at [N];
  bit rst_at [N];
  bit btn_m  [2][N];

  int n;
  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s @edge %0d: got %b want %b", tag, n, obs, exp);
    end
  endtask

  function automatic bit s1_after(int k);
    return rst_at[k] ? 1'b0 : raw_at[k];
  endfunction

  // Level on s2 just before edge k.
  function automatic bit s2_pre(int k);
    return rst_at[k-1] ? 1'b0 : s1_after(k-2);
  endfunction

  // btn flips at edge k when s2 differed from btn on each of the last S edges
  // with no flip and no reset inside that window.
  task automatic model(input int inst, input int s, input int h, input int k,
                       output bit b, output bit bz, output bit hd);
    bit prev, flip;
    prev = btn_m[inst][k-1];
    flip = 1'b1;
    for (int j = k - s + 1; j <= k; j++) begin
      if (rst_at[j] || (s2_pre(j) == btn_m[inst][j-1])) flip = 1'b0;
      if ((j < k) && (btn_m[inst][j] != btn_m[inst][j-1])) flip = 1'b0;
    end
    b = flip ? ~prev : prev;
    if (rst_at[k]) b = 1'b0;
    btn_m[inst][k] = b;
    bz = !rst_at[k] && !flip && (s2_pre(k) != prev);
    hd = 1'b1;
    for (int j = k - h; j <= k; j++)
      if (!btn_m[inst][j] || rst_at[j]) hd = 1'b0;
  endtask

  task automatic tick();
    bit b, bz, hd;
    @(posedge clk_4);
    if (n < N - 1) n++;
    raw_at[n] = raw;
    rst_at[n] = reset;
    #1;
    model(0, S_A, H_A, n, b, bz, hd);
    chk("a_btn",  bus_a.btn_signal, b);
    chk("a_busy", bus_a.busy, bz);
    chk("a_held", bus_a.held, hd);
    model(1, S_B, H_B, n, b, bz, hd);
    chk("b_btn",  bus_b.btn_signal, b);
    chk("b_busy", bus_b.busy, bz);
    chk("b_held", bus_b.held, hd);
  endtask

  task automatic hold_level(input bit lvl, input int cycles);
    raw = lvl;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b1;
    #1;
    chk("rst_a_btn",  bus_a.btn_signal, 1'b0);
    chk("rst_a_busy", bus_a.busy, 1'b0);
    chk("rst_a_held", bus_a.held, 1'b0);
    chk("rst_b_btn",  bus_b.btn_signal, 1'b0);
    chk("rst_b_held", bus_b.held, 1'b0);
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < START; i++) begin
      raw_at[i]   = 1'b0;
      rst_at[i]   = 1'b1;
      btn_m[0][i] = 1'b0;
      btn_m[1][i] = 1'b0;
    end
    n     = START - 1;
    raw   = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    hold_level(1'b0, 5);

    // Clean press held long, then release from held.
    hold_level(1'b1, 20);
    hold_level(1'b0, 20);

    // Glitch shorter than the window.
    hold_level(1'b1, 3);
    hold_level(1'b0, 10);

    // Bounce pattern settling high, then release.
    hold_level(1'b1, 1);
    hold_level(1'b0, 1);
    hold_level(1'b1, 2);
    hold_level(1'b0, 1);
    hold_level(1'b1, 20);
    hold_level(1'b0, 15);

    // Reset in mid-qualification, released with the button still down.
    hold_level(1'b1, 4);
    pulse_reset(2);
    hold_level(1'b1, 20);
    hold_level(1'b0, 15);

    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, 3));
      hold_level(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    hold_level(1'b0, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
